dmi_arb_buf: RTL and testbench
==============================

Name: dmi_arb_buf

Overview:
- Single-clock N-channel DMI request arbiter and response router.
- Sits between several DMI masters and one debug-module DMI slave on the core clock. Typical masters are the JTAG CDC output and an on-chip debug port.
- Registers and round-robin arbitrates requests, tracks outstanding transactions in an in-order ID FIFO, and routes each response back to its issuer.
- Per-channel synchronous clear discards the responses of a channel that resets mid-transaction.

Parameters:
NumCh, 2, number of DMI master channels (>=1)
Depth, 4, max outstanding transactions tracked in ID FIFO (>=1)
ReqWidth, 41, DMI request payload width (addr 7 + data 32 + op 2)
RespWidth, 34, DMI response payload width (data 32 + resp 2)

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous reset, active high
ch_req_i  in  NumCh*ReqWidth  per-channel request payload, channel c at [c*ReqWidth +: ReqWidth]
ch_req_valid_i  in  NumCh  per-channel request valid
ch_req_ready_o  out  NumCh  per-channel request accept (one-hot or zero)
ch_clear_i  in  NumCh  per-channel synchronous clear
ch_resp_o  out  NumCh*RespWidth  response payload, replicated to all channels
ch_resp_valid_o  out  NumCh  per-channel response valid (one-hot or zero)
ch_resp_ready_i  in  NumCh  per-channel response ready
dm_req_o  out  ReqWidth  request to DM
dm_req_valid_o  out  1  request valid to DM
dm_req_ready_i  in  1  DM request ready
dm_resp_i  in  RespWidth  DM response payload
dm_resp_valid_i  in  1  DM response valid
dm_resp_ready_o  out  1  response ready to DM
busy_o  out  1  transaction in flight
orphan_cnt_o  out  8  orphan response count (see Optional Feature)

Behaviour:
- Reset (rst_i high, async): output stage empty, ID FIFO empty, RR pointer = 0 (channel 0 highest priority), orphan count 0. All outputs read 0 while reset is asserted.
- Grant-eligible condition:
  - output stage empty, or output stage handshaking this cycle (dm_req_valid_o && dm_req_ready_i);
  - and ID FIFO count < Depth.
  - No push-on-pop bypass when the FIFO is full.
- Arbitration:
  - Round robin over channels c with ch_req_valid_i[c] && !ch_clear_i[c], searching from the RR pointer upward with wrap.
  - ch_req_ready_o[c] = eligible && grant[c]. This is combinational from valid, which masters must tolerate.
  - On grant to channel c, the RR pointer becomes (c+1) mod NumCh. The pointer is unchanged when there is no grant.
- Request output stage:
  - On grant, the payload is registered. dm_req_valid_o rises the next cycle (latency 1).
  - Payload and valid are held stable until dm_req_ready_i. There is no retraction, even on ch_clear_i.
- ID FIFO push: on grant, push {channel index, drop=0}.
- ch_clear_i[c] (synchronous): every FIFO entry whose index is c gets drop=1 in that cycle. This includes an entry pushed in the same cycle for channel c, which cannot occur because clear masks grant.
- Response path (combinational, zero latency):
  - When FIFO is non-empty with head {h, d}:
    - ch_resp_valid_o[h] = dm_resp_valid_i && !d;
    - dm_resp_ready_o = d || ch_resp_ready_i[h].
  - A clear of channel h in the same cycle as the head is presented forces drop behaviour immediately.
  - ch_resp_o carries dm_resp_i on every channel.
- FIFO pop: on dm_resp_valid_i && dm_resp_ready_o.
- Same-cycle push and pop: count is unchanged. With Depth=1, push is blocked while full even during a pop.
- Orphan response (dm_resp_valid_i while FIFO empty): dm_resp_ready_o=1, no channel valid, response discarded, orphan count incremented (feature enabled).
- busy_o = FIFO non-empty || dm_req_valid_o.
- NumCh=1: RR degenerates, pointer stays 0.

Optional Feature:
- Macro: DMI_ARB_ORPHAN_CNT_EN.
- Defined: 8-bit saturating counter (stops at 255) counts orphan responses; orphan_cnt_o = counter; cleared only by rst_i.
- Undefined: no counter flops; orphan_cnt_o tied to 0; orphan responses still accepted and discarded.

Test Plan:
- NumCh=2, Depth=4, both channels request every cycle, dm_req_ready_i=1 -> grants alternate 0,1,0,1; dm_req_valid_o first high 1 cycle after first grant; payload matches the granted channel.
- dm_req_ready_i=0 for 5 cycles with ch0 valid -> dm_req_o stable, ch_req_ready_o=0 after first grant, busy_o=1.
- Issue 4 requests with no responses -> 5th request is not granted (FIFO full); one response popped -> next cycle grant resumes.
- Requests ch0, ch1, ch0 outstanding; pulse ch_clear_i[0]; DM returns 3 responses -> only ch1 sees ch_resp_valid_o; the ch0 responses are accepted with dm_resp_ready_o=1 regardless of ch_resp_ready_i.
- Head response for ch1 with ch_resp_ready_i[1]=0 for 3 cycles -> dm_resp_ready_o=0, FIFO count unchanged; ready high -> pop.
- With DMI_ARB_ORPHAN_CNT_EN, 300 responses into empty FIFO -> orphan_cnt_o=255, no channel valid. Without the macro -> orphan_cnt_o=0. Assert rst_i mid-transaction -> all outputs 0 immediately.

Source files
------------

// File: rtl/dmi_arb_buf.sv
// N-channel DMI request arbiter / response router with in-order ID FIFO.
// Optional orphan-response counter enabled by defining DMI_ARB_ORPHAN_CNT_EN.
module dmi_arb_buf #(
  parameter int NumCh     = 2,
  parameter int Depth     = 4,
  parameter int ReqWidth  = 41,
  parameter int RespWidth = 34
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumCh*ReqWidth-1:0]  ch_req_i,
  input  logic [NumCh-1:0]           ch_req_valid_i,
  output logic [NumCh-1:0]           ch_req_ready_o,
  input  logic [NumCh-1:0]           ch_clear_i,
  output logic [NumCh*RespWidth-1:0] ch_resp_o,
  output logic [NumCh-1:0]           ch_resp_valid_o,
  input  logic [NumCh-1:0]           ch_resp_ready_i,
  output logic [ReqWidth-1:0]        dm_req_o,
  output logic                       dm_req_valid_o,
  input  logic                       dm_req_ready_i,
  input  logic [RespWidth-1:0]       dm_resp_i,
  input  logic                       dm_resp_valid_i,
  output logic                       dm_resp_ready_o,
  output logic                       busy_o,
  output logic [7:0]                 orphan_cnt_o
);

  localparam int IdxW = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [ReqWidth-1:0] req_pl_q, req_pl_d;
  logic                req_vld_q, req_vld_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic [IdxW-1:0]     fifo_idx_q [Depth];
  logic [IdxW-1:0]     fifo_idx_d [Depth];
  logic [Depth-1:0]    fifo_drop_q, fifo_drop_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic [NumCh-1:0] req_cand_s, grant_s, resp_vld_s;
  logic [IdxW-1:0]  gnt_idx_s, head_idx_s;
  logic             gnt_any_s, eligible_s, push_s, pop_s, nonempty_s;
  logic             head_drop_s, resp_rdy_s;

  assign req_cand_s = ch_req_valid_i & ~ch_clear_i;
  assign nonempty_s = (cnt_q != '0);
  assign eligible_s = (!req_vld_q || dm_req_ready_i) && (cnt_q < CntW'(Depth));
  assign push_s     = eligible_s && gnt_any_s;

  // Round-robin search starting at the pointer, wrapping past the last channel
  always_comb begin
    int cand;
    cand      = 0;
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    for (int k = 0; k < NumCh; k++) begin
      cand = int'(rr_q) + k;
      cand = (cand >= NumCh) ? cand - NumCh : cand;
      if (!gnt_any_s && req_cand_s[cand]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = IdxW'(cand);
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
    grant_s = gnt_any_s ? (NumCh'(1) << gnt_idx_s) : '0;
  end

  // A clear arriving with the head entry drops it in the same cycle
  assign head_idx_s  = fifo_idx_q[rd_ptr_q];
  assign head_drop_s = fifo_drop_q[rd_ptr_q] || ch_clear_i[head_idx_s];

  // Response steering toward the head entry's issuer
  always_comb begin
    resp_vld_s = '0;
    resp_rdy_s = 1'b1;
    if (nonempty_s) begin
      resp_vld_s[head_idx_s] = dm_resp_valid_i && !head_drop_s;
      resp_rdy_s             = head_drop_s || ch_resp_ready_i[head_idx_s];
    end else begin
      resp_rdy_s = 1'b1;
    end
  end

  assign pop_s = nonempty_s && dm_resp_valid_i && resp_rdy_s;

  // Next-state for output stage, RR pointer and ID FIFO
  always_comb begin
    req_pl_d    = req_pl_q;
    req_vld_d   = req_vld_q;
    rr_d        = rr_q;
    fifo_idx_d  = fifo_idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    for (int i = 0; i < Depth; i++) begin
      fifo_drop_d[i] = fifo_drop_q[i] | ch_clear_i[fifo_idx_q[i]];
    end
    if (push_s) begin
      req_pl_d               = ch_req_i[gnt_idx_s*ReqWidth +: ReqWidth];
      req_vld_d              = 1'b1;
      rr_d                   = (int'(gnt_idx_s) == NumCh - 1) ? '0 : gnt_idx_s + 1'b1;
      fifo_idx_d[wr_ptr_q]   = gnt_idx_s;
      fifo_drop_d[wr_ptr_q]  = 1'b0;
      wr_ptr_d               = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end else if (dm_req_ready_i) begin
      req_vld_d = 1'b0;
    end else begin
      req_vld_d = req_vld_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_pl_q    <= '0;
      req_vld_q   <= 1'b0;
      rr_q        <= '0;
      fifo_idx_q  <= '{default: '0};
      fifo_drop_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      req_pl_q    <= req_pl_d;
      req_vld_q   <= req_vld_d;
      rr_q        <= rr_d;
      fifo_idx_q  <= fifo_idx_d;
      fifo_drop_q <= fifo_drop_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef DMI_ARB_ORPHAN_CNT_EN
  logic [7:0] orphan_cnt_q, orphan_cnt_d;
  logic       orphan_s;

  assign orphan_s = !nonempty_s && dm_resp_valid_i;

  // Saturating orphan counter
  always_comb begin
    orphan_cnt_d = (orphan_s && (orphan_cnt_q != 8'hFF)) ? orphan_cnt_q + 8'd1 : orphan_cnt_q;
  end

  // Orphan counter register, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      orphan_cnt_q <= 8'd0;
    end else begin
      orphan_cnt_q <= orphan_cnt_d;
    end
  end

  assign orphan_cnt_o = orphan_cnt_q;
`else
  assign orphan_cnt_o = 8'd0;
`endif

  // Combinational outputs are forced low while reset is held
  assign ch_req_ready_o  = (push_s && !rst_i) ? grant_s : '0;
  assign ch_resp_valid_o = rst_i ? '0 : resp_vld_s;
  assign dm_resp_ready_o = resp_rdy_s && !rst_i;
  assign ch_resp_o       = rst_i ? '0 : {NumCh{dm_resp_i}};
  assign dm_req_o        = req_pl_q;
  assign dm_req_valid_o  = req_vld_q;
  assign busy_o          = nonempty_s || req_vld_q;

endmodule

// File: tb/tb_dmi_arb_buf.sv
// Self-checking bench for dmi_arb_buf: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_dmi_arb_buf;
  localparam int NumCh = 2;
  localparam int Depth = 4;
  localparam int ReqW  = 41;
  localparam int RespW = 34;
`ifdef DMI_ARB_ORPHAN_CNT_EN
  localparam bit OrphEn = 1'b1;
`else
  localparam bit OrphEn = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NumCh*ReqW-1:0]   ch_req;
  logic [NumCh-1:0]        ch_req_valid, ch_req_ready, ch_clear;
  logic [NumCh*RespW-1:0]  ch_resp;
  logic [NumCh-1:0]        ch_resp_valid, ch_resp_ready;
  logic [ReqW-1:0]         dm_req;
  logic                    dm_req_valid, dm_req_ready;
  logic [RespW-1:0]        dm_resp;
  logic                    dm_resp_valid, dm_resp_ready, busy;
  logic [7:0]              orphan_cnt;

  dmi_arb_buf #(.NumCh(NumCh), .Depth(Depth), .ReqWidth(ReqW), .RespWidth(RespW)) dut (
    .clk_i(clk), .rst_i(rst),
    .ch_req_i(ch_req), .ch_req_valid_i(ch_req_valid), .ch_req_ready_o(ch_req_ready),
    .ch_clear_i(ch_clear),
    .ch_resp_o(ch_resp), .ch_resp_valid_o(ch_resp_valid), .ch_resp_ready_i(ch_resp_ready),
    .dm_req_o(dm_req), .dm_req_valid_o(dm_req_valid), .dm_req_ready_i(dm_req_ready),
    .dm_resp_i(dm_resp), .dm_resp_valid_i(dm_resp_valid), .dm_resp_ready_o(dm_resp_ready),
    .busy_o(busy), .orphan_cnt_o(orphan_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] vld, clr, rrdy;
    logic       dmrdy, rv;
    logic [1:0] e_rdy;
    logic       e_qv;
    int         e_ch;
    logic [1:0] e_rsv;
    logic       e_rr, chk_rr, e_busy;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] vld, input logic [1:0] clr, input logic [1:0] rrdy,
                              input logic dmrdy, input logic rv, input logic [1:0] e_rdy,
                              input logic e_qv, input int e_ch, input logic [1:0] e_rsv,
                              input logic e_rr, input logic chk_rr, input logic e_busy);
    vec_t v;
    v.vld = vld; v.clr = clr; v.rrdy = rrdy; v.dmrdy = dmrdy; v.rv = rv;
    v.e_rdy = e_rdy; v.e_qv = e_qv; v.e_ch = e_ch; v.e_rsv = e_rsv;
    v.e_rr = e_rr; v.chk_rr = chk_rr; v.e_busy = e_busy;
    return v;
  endfunction

  typedef struct { int ch; bit drop; } ent_t;
  ent_t            mq[$];
  bit              m_ov;
  logic [ReqW-1:0] m_opl;
  int              m_rr;
  int              m_orph;

  localparam logic [ReqW-1:0] PL0 = 41'h0_DEAD_BEEF_1;
  localparam logic [ReqW-1:0] PL1 = 41'h1_CAFE_F00D_2;

  task automatic idle_inputs();
    ch_req = '0; ch_req_valid = '0; ch_clear = '0; ch_resp_ready = '0;
    dm_req_ready = 1'b0; dm_resp = '0; dm_resp_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, ch_req_ready, 2'b00);
    chk({tag, "_resp_valid"}, ch_resp_valid, 2'b00);
    chk({tag, "_resp_data"}, ch_resp, 68'd0);
    chk({tag, "_dm_req"}, dm_req, 41'd0);
    chk({tag, "_dm_req_valid"}, dm_req_valid, 1'b0);
    chk({tag, "_dm_resp_ready"}, dm_resp_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_orphan"}, orphan_cnt, 8'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); m_ov = 1'b0; m_opl = '0; m_rr = 0; m_orph = 0;
  endtask

  initial begin
    vec_t tv[14];
    logic [95:0] r96;
    logic [63:0] r64;
    logic [ReqW-1:0] held;

    rst = 1'b1;
    idle_inputs();
    dm_resp_valid = 1'b1;
    ch_req_valid  = 2'b11;
    ch_resp_ready = 2'b11;
    dm_resp = 34'h2_1234_5678;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    // ---- directed table: alternation, FIFO full, clear/drop, response backpressure, orphan
    tv[0]  = mk(2'b11, 2'b00, 2'b11, 1'b1, 1'b0, 2'b01, 1'b0, 0, 2'b00, 1'b1, 1'b0, 1'b0);
    tv[1]  = mk(2'b11, 2'b00, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 0, 2'b00, 1'b1, 1'b1, 1'b1);
    tv[2]  = mk(2'b11, 2'b00, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1, 2'b00, 1'b1, 1'b1, 1'b1);
    tv[3]  = mk(2'b11, 2'b00, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 0, 2'b00, 1'b1, 1'b1, 1'b1);
    tv[4]  = mk(2'b11, 2'b00, 2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 1, 2'b00, 1'b1, 1'b1, 1'b1);
    tv[5]  = mk(2'b11, 2'b00, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 0, 2'b01, 1'b1, 1'b1, 1'b1);
    tv[6]  = mk(2'b11, 2'b00, 2'b11, 1'b1, 1'b0, 2'b01, 1'b0, 0, 2'b00, 1'b1, 1'b1, 1'b1);
    tv[7]  = mk(2'b00, 2'b01, 2'b11, 1'b0, 1'b1, 2'b00, 1'b1, 0, 2'b10, 1'b1, 1'b1, 1'b1);
    tv[8]  = mk(2'b00, 2'b00, 2'b11, 1'b0, 1'b1, 2'b00, 1'b1, 0, 2'b00, 1'b1, 1'b1, 1'b1);
    tv[9]  = mk(2'b01, 2'b01, 2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 0, 2'b00, 1'b1, 1'b1, 1'b1);
    tv[10] = mk(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 0, 2'b10, 1'b0, 1'b1, 1'b1);
    tv[11] = mk(2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 0, 2'b10, 1'b1, 1'b1, 1'b1);
    tv[12] = mk(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 0, 2'b00, 1'b1, 1'b1, 1'b1);
    tv[13] = mk(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 0, 2'b00, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ch_req        = {PL1, PL0};
      ch_req_valid  = tv[i].vld;
      ch_clear      = tv[i].clr;
      ch_resp_ready = tv[i].rrdy;
      dm_req_ready  = tv[i].dmrdy;
      dm_resp_valid = tv[i].rv;
      r64 = {$urandom(), $urandom()};
      dm_resp = r64[RespW-1:0];
      #2;
      chk($sformatf("tv%0d_req_ready", i), ch_req_ready, tv[i].e_rdy);
      chk($sformatf("tv%0d_dm_req_valid", i), dm_req_valid, tv[i].e_qv);
      if (tv[i].e_qv) chk($sformatf("tv%0d_dm_req", i), dm_req, (tv[i].e_ch == 1) ? PL1 : PL0);
      chk($sformatf("tv%0d_resp_valid", i), ch_resp_valid, tv[i].e_rsv);
      if (tv[i].chk_rr) chk($sformatf("tv%0d_dm_resp_ready", i), dm_resp_ready, tv[i].e_rr);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("tv%0d_resp_data", i), ch_resp, {dm_resp, dm_resp});
    end
    @(negedge clk);
    idle_inputs();
    #2;
    chk("tv_orphan_after", orphan_cnt, OrphEn ? 8'd1 : 8'd0);

    // ---- stall: ch0 held while DM not ready, then reset mid-transaction
    ch_req = {PL1, PL0};
    ch_req_valid = 2'b01;
    #1;
    chk("stall_first_grant", ch_req_ready, 2'b01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      chk("stall_req_ready", ch_req_ready, 2'b00);
      chk("stall_dm_valid", dm_req_valid, 1'b1);
      chk("stall_dm_req", dm_req, PL0);
      chk("stall_busy", busy, 1'b1);
    end
    @(negedge clk);
    dm_req_ready  = 1'b1;
    dm_resp_valid = 1'b1;
    ch_resp_ready = 2'b11;
    dm_resp       = 34'h3_0F0F_0F0F;
    #1;
    chk("pre_rst_resp_valid", ch_resp_valid, 2'b01);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    // ---- orphans into an empty FIFO
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      dm_resp_valid = 1'b1;
      dm_resp = 34'(i);
      #2;
      chk("orphan_resp_valid", ch_resp_valid, 2'b00);
      chk("orphan_ready", dm_resp_ready, 1'b1);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    chk("orphan_cnt_sat", orphan_cnt, OrphEn ? 8'd255 : 8'd0);

    // ---- randomized traffic against the reference model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      int h;
      bit d, elig, chk_rr, was_empty;
      logic [1:0] e_rdy, e_rsv;
      logic e_rr;
      if (cyc != 0) @(negedge clk);
      r96 = {$urandom(), $urandom(), $urandom()};
      ch_req = r96[NumCh*ReqW-1:0];
      ch_req_valid = 2'($urandom_range(0, 3));
      for (int c = 0; c < NumCh; c++) ch_clear[c] = ($urandom_range(0, 9) == 0);
      ch_resp_ready = 2'($urandom_range(0, 3));
      dm_req_ready  = ($urandom_range(0, 9) < 7);
      dm_resp_valid = 1'($urandom_range(0, 1));
      r64 = {$urandom(), $urandom()};
      dm_resp = r64[RespW-1:0];
      #2;
      elig = (!m_ov || dm_req_ready) && (mq.size() < Depth);
      g = -1;
      for (int k = 0; k < NumCh; k++) begin
        int c;
        c = (m_rr + k) % NumCh;
        if (g < 0 && ch_req_valid[c] && !ch_clear[c]) g = c;
      end
      e_rdy = (elig && g >= 0) ? (2'b01 << g) : 2'b00;
      e_rsv = 2'b00; e_rr = 1'b1; chk_rr = 1'b0;
      was_empty = (mq.size() == 0);
      if (!was_empty) begin
        h = mq[0].ch;
        d = mq[0].drop || ch_clear[h];
        e_rsv = (dm_resp_valid && !d) ? (2'b01 << h) : 2'b00;
        e_rr = d || ch_resp_ready[h];
        chk_rr = 1'b1;
      end else if (dm_resp_valid) begin
        chk_rr = 1'b1;
      end
      chk("rnd_req_ready", ch_req_ready, e_rdy);
      chk("rnd_dm_req_valid", dm_req_valid, m_ov);
      if (m_ov) chk("rnd_dm_req", dm_req, m_opl);
      chk("rnd_busy", busy, (!was_empty) || m_ov);
      chk("rnd_resp_valid", ch_resp_valid, e_rsv);
      if (chk_rr) chk("rnd_dm_resp_ready", dm_resp_ready, e_rr);
      chk("rnd_resp_data", ch_resp, {dm_resp, dm_resp});
      chk("rnd_orphan", orphan_cnt, OrphEn ? 8'(m_orph) : 8'd0);
      if (!was_empty && dm_resp_valid && e_rr) void'(mq.pop_front());
      else if (was_empty && dm_resp_valid && m_orph < 255) m_orph++;
      foreach (mq[i]) if (ch_clear[mq[i].ch]) mq[i].drop = 1'b1;
      if (e_rdy != 2'b00) begin
        ent_t e;
        e.ch = g; e.drop = 1'b0;
        mq.push_back(e);
        m_opl = ch_req[g*ReqW +: ReqW];
        m_ov  = 1'b1;
        m_rr  = (g + 1) % NumCh;
      end else if (dm_req_ready) begin
        m_ov = 1'b0;
      end
    end
    held = m_opl;
    @(negedge clk);
    idle_inputs();
    if (m_ov) begin
      #2;
      chk("rnd_final_req", dm_req, held);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
